ysyx_22041207_ex_mem_buf: RTL and testbench

- Downstream neighbour of the execute-stage ALU.
- Pairs each issued instruction's metadata (rd, write-enable, memory op, store data, pc) with the ALU's registered result, which appears one or more cycles later.
- Absorbs multi-cycle ALU ops signalled by `alu_wait`, then hands complete entries to the MEM stage through a small FIFO with a valid/ready handshake.
- Generates the back-pressure signal `ex_ready` seen by the issue logic.

---
 rtl/ysyx_22041207_ex_mem_buf_if.sv | 37 +++
 rtl/ysyx_22041207_ex_mem_buf.sv | 140 ++++++++++++++
 tb/tb_ysyx_22041207_ex_mem_buf.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041207_ex_mem_buf_if.sv
// EX -> MEM buffer bus: issue handshake, ALU result/busy, and the MEM-side FIFO head.
// slave is the buffer itself; master is the surrounding pipeline (EX issue logic + MEM stage).
interface ysyx_22041207_ex_mem_buf_if #(
    parameter int XLEN = 64
);
    logic            ex_valid;
    logic            ex_ready;
    logic [4:0]      ex_rd;
    logic            ex_wen;
    logic [3:0]      ex_memop;
    logic [XLEN-1:0] ex_store_data;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] alu_res;
    logic            alu_wait;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic [4:0]      out_rd;
    logic            out_wen;
    logic [3:0]      out_memop;
    logic [XLEN-1:0] out_store_data;
    logic [XLEN-1:0] out_pc;

    modport master (
        output ex_valid, ex_rd, ex_wen, ex_memop, ex_store_data, ex_pc,
        output alu_res, alu_wait, out_ready,
        input  ex_ready, out_valid, out_res, out_rd, out_wen, out_memop,
        input  out_store_data, out_pc
    );

    modport slave (
        input  ex_valid, ex_rd, ex_wen, ex_memop, ex_store_data, ex_pc,
        input  alu_res, alu_wait, out_ready,
        output ex_ready, out_valid, out_res, out_rd, out_wen, out_memop,
        output out_store_data, out_pc
    );
endinterface

// File: rtl/ysyx_22041207_ex_mem_buf.sv
// Pairs issued EX metadata with the ALU's later result and queues complete entries for MEM.
// A one-entry tag holds the in-flight instruction; a DEPTH-entry FIFO feeds the MEM stage.
module ysyx_22041207_ex_mem_buf #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    ysyx_22041207_ex_mem_buf_if.slave     bus,
    output logic [31:0]                   stall_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic            tag_valid_reg;
    logic            tag_done_reg;
    logic [4:0]      tag_rd_reg;
    logic            tag_wen_reg;
    logic [3:0]      tag_memop_reg;
    logic [XLEN-1:0] tag_store_reg;
    logic [XLEN-1:0] tag_pc_reg;
    logic [XLEN-1:0] tag_res_reg;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      stall_cnt_reg;

    logic [XLEN-1:0] mem_res   [DEPTH];
    logic [4:0]      mem_rd    [DEPTH];
    logic            mem_wen   [DEPTH];
    logic [3:0]      mem_memop [DEPTH];
    logic [XLEN-1:0] mem_store [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];

    logic            pop;
    logic            space;
    logic            complete;
    logic            push;
    logic            issue;
    logic [XLEN-1:0] push_res;

    assign pop      = (count_reg != '0) && bus.out_ready;
    assign space    = (count_reg < CNT_W'(DEPTH)) || pop;
    assign complete = tag_valid_reg && !tag_done_reg && !bus.alu_wait;
    assign push     = !flush && tag_valid_reg && (tag_done_reg || complete) && space;
    // A latched result must win: alu_res may already belong to a later op.
    assign push_res = tag_done_reg ? tag_res_reg : bus.alu_res;
    assign issue    = bus.ex_valid && bus.ex_ready;

    assign bus.ex_ready = !flush && (!tag_valid_reg || push);

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_reg <= 1'b0;
            tag_done_reg  <= 1'b0;
            tag_rd_reg    <= '0;
            tag_wen_reg   <= 1'b0;
            tag_memop_reg <= '0;
            tag_store_reg <= '0;
            tag_pc_reg    <= '0;
            tag_res_reg   <= '0;
        end else if (flush) begin
            tag_valid_reg <= 1'b0;
            tag_done_reg  <= 1'b0;
        end else if (issue) begin
            tag_valid_reg <= 1'b1;
            tag_done_reg  <= 1'b0;
            tag_rd_reg    <= bus.ex_rd;
            tag_wen_reg   <= bus.ex_wen;
            tag_memop_reg <= bus.ex_memop;
            tag_store_reg <= bus.ex_store_data;
            tag_pc_reg    <= bus.ex_pc;
        end else if (push) begin
            tag_valid_reg <= 1'b0;
            tag_done_reg  <= 1'b0;
        end else if (complete) begin
            // FIFO full: keep the sampled result, a held multi-cycle op would restart.
            tag_res_reg  <= bus.alu_res;
            tag_done_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_res[gi]   <= '0;
                    mem_rd[gi]    <= '0;
                    mem_wen[gi]   <= 1'b0;
                    mem_memop[gi] <= '0;
                    mem_store[gi] <= '0;
                    mem_pc[gi]    <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_res[gi]   <= push_res;
                    mem_rd[gi]    <= tag_rd_reg;
                    mem_wen[gi]   <= tag_wen_reg;
                    mem_memop[gi] <= tag_memop_reg;
                    mem_store[gi] <= tag_store_reg;
                    mem_pc[gi]    <= tag_pc_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (bus.ex_valid && !bus.ex_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt          = stall_cnt_reg;
    assign bus.out_valid      = (count_reg != '0);
    assign bus.out_res        = mem_res[rd_ptr_reg];
    assign bus.out_rd         = mem_rd[rd_ptr_reg];
    assign bus.out_wen        = mem_wen[rd_ptr_reg];
    assign bus.out_memop      = mem_memop[rd_ptr_reg];
    assign bus.out_store_data = mem_store[rd_ptr_reg];
    assign bus.out_pc         = mem_pc[rd_ptr_reg];
endmodule

// File: tb/tb_ysyx_22041207_ex_mem_buf.sv
// Directed bench for the EX->MEM buffer: latency, throughput, multi-cycle wait, full FIFO,
// flush and reset, with expected values worked out by hand for each cycle.
module tb_ysyx_22041207_ex_mem_buf;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] stall_cnt;
    int          check_cnt = 0;
    int          pass_cnt  = 0;

    always #5 clk = ~clk;

    ysyx_22041207_ex_mem_buf_if #(.XLEN(64)) bus ();

    ysyx_22041207_ex_mem_buf #(.DEPTH(2), .XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("ok   %-14s got=%0h", tag, got);
        end else begin
            $display("FAIL %-14s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [4:0] rd, input logic wen,
                          input logic [3:0] memop, input logic [63:0] sd, input logic [63:0] pc);
        bus.ex_valid      = v;
        bus.ex_rd         = rd;
        bus.ex_wen        = wen;
        bus.ex_memop      = memop;
        bus.ex_store_data = sd;
        bus.ex_pc         = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [31:0] stall0;
        int          ready_hi;

        rst   = 1'b1;
        flush = 1'b0;
        set_ex(1'b0, 5'd0, 1'b0, 4'd0, 64'd0, 64'd0);
        bus.alu_res   = 64'd0;
        bus.alu_wait  = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        settle();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ex_ready", 64'(bus.ex_ready), 64'd1);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_out_res", bus.out_res, 64'd0);

        // single ADD: result one cycle after issue, visible two cycles after issue
        bus.out_ready = 1'b1;
        set_ex(1'b1, 5'd5, 1'b1, 4'd0, 64'd0, 64'h8000_0000);
        settle();
        chk("t1_ready", 64'(bus.ex_ready), 64'd1);
        cyc();
        set_ex(1'b0, 5'd0, 1'b0, 4'd0, 64'd0, 64'd0);
        bus.alu_res = 64'h3;
        settle();
        chk("t1_not_yet", 64'(bus.out_valid), 64'd0);
        cyc();
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_res", bus.out_res, 64'h3);
        chk("t1_rd", 64'(bus.out_rd), 64'd5);
        chk("t1_wen", 64'(bus.out_wen), 64'd1);
        chk("t1_pc", bus.out_pc, 64'h8000_0000);
        cyc();
        chk("t1_drained", 64'(bus.out_valid), 64'd0);

        // four back-to-back single-cycle ops
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_ex(1'b1, 5'(i + 1), 1'b1, 4'd0, 64'd0, 64'(32'h100 + 4 * i));
            else       set_ex(1'b0, 5'd0, 1'b0, 4'd0, 64'd0, 64'd0);
            bus.alu_res = 64'(i);
            settle();
            if (i < 4) chk("t2_ready", 64'(bus.ex_ready), 64'd1);
            if (i < 2) begin
                chk("t2_empty", 64'(bus.out_valid), 64'd0);
            end else begin
                chk("t2_valid", 64'(bus.out_valid), 64'd1);
                chk("t2_res", bus.out_res, 64'(i - 1));
                chk("t2_pc", bus.out_pc, 64'(32'h100 + 4 * (i - 2)));
            end
            cyc();
        end
        chk("t2_drained", 64'(bus.out_valid), 64'd0);

        // multi-cycle MUL held for 22 cycles with the next instruction waiting
        stall0 = stall_cnt;
        set_ex(1'b1, 5'd7, 1'b1, 4'd0, 64'd0, 64'h200);
        settle();
        chk("t3_issue", 64'(bus.ex_ready), 64'd1);
        cyc();
        set_ex(1'b1, 5'd8, 1'b1, 4'd0, 64'd0, 64'h204);
        bus.alu_wait = 1'b1;
        ready_hi = 0;
        for (int i = 0; i < 22; i++) begin
            settle();
            if (bus.ex_ready) ready_hi++;
            cyc();
        end
        bus.alu_wait = 1'b0;
        bus.alu_res  = 64'h2A;
        settle();
        chk("t3_ready_wait", 64'(ready_hi), 64'd0);
        chk("t3_stall", 64'(stall_cnt), 64'(stall0 + 32'd22));
        chk("t3_ready_done", 64'(bus.ex_ready), 64'd1);
        cyc();
        set_ex(1'b0, 5'd0, 1'b0, 4'd0, 64'd0, 64'd0);
        bus.alu_res = 64'h55;
        settle();
        chk("t3_valid", 64'(bus.out_valid), 64'd1);
        chk("t3_res", bus.out_res, 64'h2A);
        chk("t3_pc", bus.out_pc, 64'h200);
        cyc();
        chk("t3_res2", bus.out_res, 64'h55);
        chk("t3_pc2", bus.out_pc, 64'h204);
        cyc();
        chk("t3_drained", 64'(bus.out_valid), 64'd0);

        // full FIFO: third result latched, later alu_res changes must not leak in
        bus.out_ready = 1'b0;
        set_ex(1'b1, 5'd10, 1'b1, 4'h2, 64'h1234, 64'h300);
        cyc();
        set_ex(1'b1, 5'd11, 1'b0, 4'h0, 64'd0, 64'h304);
        bus.alu_res = 64'h11;
        cyc();
        set_ex(1'b1, 5'd12, 1'b1, 4'h0, 64'd0, 64'h308);
        bus.alu_res = 64'h22;
        settle();
        chk("t4_ready_c", 64'(bus.ex_ready), 64'd1);
        cyc();
        set_ex(1'b0, 5'd0, 1'b0, 4'd0, 64'd0, 64'd0);
        bus.alu_res = 64'h33;
        settle();
        chk("t4_full_rdy", 64'(bus.ex_ready), 64'd0);
        cyc();
        bus.alu_res = 64'h99;
        settle();
        chk("t4_done_rdy", 64'(bus.ex_ready), 64'd0);
        chk("t4_valid", 64'(bus.out_valid), 64'd1);
        chk("t4_res_a", bus.out_res, 64'h11);
        chk("t4_memop_a", 64'(bus.out_memop), 64'h2);
        chk("t4_sd_a", bus.out_store_data, 64'h1234);
        cyc();
        bus.out_ready = 1'b1;
        settle();
        chk("t4_pushpop", 64'(bus.ex_ready), 64'd1);
        cyc();
        chk("t4_res_b", bus.out_res, 64'h22);
        chk("t4_wen_b", 64'(bus.out_wen), 64'd0);
        chk("t4_memop_b", 64'(bus.out_memop), 64'd0);
        cyc();
        chk("t4_res_c", bus.out_res, 64'h33);
        chk("t4_pc_c", bus.out_pc, 64'h308);
        cyc();
        chk("t4_drained", 64'(bus.out_valid), 64'd0);

        // flush the tagged instruction while one older entry sits in the FIFO
        bus.out_ready = 1'b0;
        set_ex(1'b1, 5'd13, 1'b1, 4'd0, 64'd0, 64'h400);
        cyc();
        set_ex(1'b0, 5'd0, 1'b0, 4'd0, 64'd0, 64'd0);
        bus.alu_res = 64'h44;
        cyc();
        set_ex(1'b1, 5'd14, 1'b1, 4'd0, 64'd0, 64'h404);
        settle();
        chk("t5_issue", 64'(bus.ex_ready), 64'd1);
        cyc();
        set_ex(1'b0, 5'd0, 1'b0, 4'd0, 64'd0, 64'd0);
        flush = 1'b1;
        bus.alu_res = 64'h55;
        settle();
        chk("t5_flush_rdy", 64'(bus.ex_ready), 64'd0);
        cyc();
        flush = 1'b0;
        settle();
        chk("t5_after_rdy", 64'(bus.ex_ready), 64'd1);
        chk("t5_valid", 64'(bus.out_valid), 64'd1);
        chk("t5_res", bus.out_res, 64'h44);
        bus.out_ready = 1'b1;
        cyc();
        chk("t5_popped", 64'(bus.out_valid), 64'd0);
        cyc();
        cyc();
        chk("t5_no_ghost", 64'(bus.out_valid), 64'd0);

        // reset with FIFO full and a MUL waiting
        bus.out_ready = 1'b0;
        set_ex(1'b1, 5'd15, 1'b1, 4'd0, 64'd0, 64'h500);
        cyc();
        set_ex(1'b1, 5'd16, 1'b1, 4'd0, 64'd0, 64'h504);
        bus.alu_res = 64'h1;
        cyc();
        set_ex(1'b1, 5'd17, 1'b1, 4'd0, 64'd0, 64'h508);
        bus.alu_res = 64'h2;
        cyc();
        set_ex(1'b1, 5'd18, 1'b1, 4'd0, 64'd0, 64'h50c);
        bus.alu_wait = 1'b1;
        cyc();
        cyc();
        chk("t6_pre_valid", 64'(bus.out_valid), 64'd1);
        chk("t6_pre_rdy", 64'(bus.ex_ready), 64'd0);
        chk("t6_pre_stall", 64'(stall_cnt != 32'd0), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.alu_wait = 1'b0;
        set_ex(1'b0, 5'd0, 1'b0, 4'd0, 64'd0, 64'd0);
        settle();
        chk("t6_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_ready", 64'(bus.ex_ready), 64'd1);
        chk("t6_stall", 64'(stall_cnt), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("t6_no_stale", 64'(bus.out_valid), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
